// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RISC-V MEM stage: data-memory handshake, load extension, MEM/WB bundle
module mem_access_stage #(
    parameter int ADDR_W = 64,
    parameter int REG_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              EXMEM_ready,
    input  logic [63:0]       exmm_aluresult,
    input  logic [REG_W-1:0]  dest_reg,
    input  logic              mem_active,
    input  logic              load,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [63:0]       store_data,
    output logic              mem_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_wsize,
    output logic [63:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [63:0]       mem_rdata,
    output logic              MEMWB_ready,
    output logic [REG_W-1:0]  wb_reg,
    output logic [63:0]       wb_value,
    output logic              wb_we,
    output logic              misalign_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [1:0]         size_q, size_d;
    logic               uns_q, uns_d;
    logic [63:0]        wdata_q, wdata_d;
    logic [REG_W-1:0]   dest_q, dest_d;
    logic               load_q, load_d;

    logic               memwb_q, memwb_d;
    logic [REG_W-1:0]   wb_reg_q, wb_reg_d;
    logic [63:0]        wb_value_q, wb_value_d;
    logic               wb_we_q, wb_we_d;
    logic               mis_q, mis_d;

    logic               misaligned;

    function automatic logic [63:0] extend_load(input logic [63:0] r,
                                                input logic [1:0]  sz,
                                                input logic        uns);
        logic [63:0] v;
        case (sz)
            2'd0:    v = uns ? {56'd0, r[7:0]}  : {{56{r[7]}},  r[7:0]};
            2'd1:    v = uns ? {48'd0, r[15:0]} : {{48{r[15]}}, r[15:0]};
            2'd2:    v = uns ? {32'd0, r[31:0]} : {{32{r[31]}}, r[31:0]};
            default: v = r;
        endcase
        return v;
    endfunction

    always_comb begin
        case (mem_size)
            2'd1:    misaligned = exmm_aluresult[0];
            2'd2:    misaligned = |exmm_aluresult[1:0];
            2'd3:    misaligned = |exmm_aluresult[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        uns_d      = uns_q;
        wdata_d    = wdata_q;
        dest_d     = dest_q;
        load_d     = load_q;
        memwb_d    = 1'b0;
        wb_reg_d   = wb_reg_q;
        wb_value_d = wb_value_q;
        wb_we_d    = 1'b0;
        mis_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (EXMEM_ready) begin
                    if (!mem_active) begin
                        memwb_d    = 1'b1;
                        wb_reg_d   = dest_reg;
                        wb_value_d = exmm_aluresult;
                        wb_we_d    = (dest_reg != '0);
                    end else if (misaligned) begin
                        // Faulting address is reported through wb_value for the trap path
                        memwb_d    = 1'b1;
                        mis_d      = 1'b1;
                        wb_reg_d   = dest_reg;
                        wb_value_d = exmm_aluresult;
                    end else begin
                        addr_d  = exmm_aluresult[ADDR_W-1:0];
                        size_d  = mem_size;
                        uns_d   = mem_unsigned;
                        wdata_d = store_data;
                        dest_d  = dest_reg;
                        load_d  = load;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    memwb_d  = 1'b1;
                    wb_reg_d = dest_q;
                    if (load_q) begin
                        wb_value_d = extend_load(mem_rdata, size_q, uns_q);
                        wb_we_d    = (dest_q != '0);
                    end else begin
                        wb_value_d = 64'd0;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            size_q     <= 2'd0;
            uns_q      <= 1'b0;
            wdata_q    <= 64'd0;
            dest_q     <= '0;
            load_q     <= 1'b0;
            memwb_q    <= 1'b0;
            wb_reg_q   <= '0;
            wb_value_q <= 64'd0;
            wb_we_q    <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            wdata_q    <= wdata_d;
            dest_q     <= dest_d;
            load_q     <= load_d;
            memwb_q    <= memwb_d;
            wb_reg_q   <= wb_reg_d;
            wb_value_q <= wb_value_d;
            wb_we_q    <= wb_we_d;
            mis_q      <= mis_d;
        end
    end

    // Request fields are only driven while the request is live
    assign mem_req      = (state_q == REQ);
    assign mem_we       = mem_req & ~load_q;
    assign mem_addr     = mem_req ? addr_q : '0;
    assign mem_wsize    = mem_req ? size_q : 2'd0;
    assign mem_wdata    = mem_req ? wdata_q : 64'd0;
    assign mem_stall    = (state_q != IDLE);

    assign MEMWB_ready  = memwb_q;
    assign wb_reg       = wb_reg_q;
    assign wb_value     = wb_value_q;
    assign wb_we        = wb_we_q;
    assign misalign_err = mis_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench for mem_access_stage
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        EXMEM_ready;
    logic [63:0] exmm_aluresult;
    logic [5:0]  dest_reg;
    logic        mem_active;
    logic        load;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [63:0] store_data;
    logic        mem_stall;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [1:0]  mem_wsize;
    logic [63:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        MEMWB_ready;
    logic [5:0]  wb_reg;
    logic [63:0] wb_value;
    logic        wb_we;
    logic        misalign_err;

    mem_access_stage #(.ADDR_W(64), .REG_W(6)) dut (
        .clk(clk), .reset(reset), .EXMEM_ready(EXMEM_ready),
        .exmm_aluresult(exmm_aluresult), .dest_reg(dest_reg),
        .mem_active(mem_active), .load(load), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .store_data(store_data),
        .mem_stall(mem_stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wsize(mem_wsize), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .MEMWB_ready(MEMWB_ready), .wb_reg(wb_reg), .wb_value(wb_value),
        .wb_we(wb_we), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  r;
        logic [63:0] v;
        logic        we;
        logic        mis;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every MEM/WB pulse is matched against the scoreboard head, including its cycle
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            total++;
            if (MEMWB_ready) begin
                if (q.size() == 0) begin
                    $display("FAIL spurious_memwb: reg=%0d val=%h at cyc %0d with nothing expected",
                             wb_reg, wb_value, cyc);
                end else begin
                    e = q.pop_front();
                    if (wb_reg === e.r && wb_value === e.v && wb_we === e.we &&
                        misalign_err === e.mis && cyc == e.cyc)
                        passed++;
                    else
                        $display("FAIL memwb: got reg=%0d val=%h we=%b mis=%b cyc=%0d expected reg=%0d val=%h we=%b mis=%b cyc=%0d",
                                 wb_reg, wb_value, wb_we, misalign_err, cyc, e.r, e.v, e.we, e.mis, e.cyc);
                end
            end else begin
                if (wb_we === 1'b0 && misalign_err === 1'b0) passed++;
                else $display("FAIL idle_wb: wb_we=%b misalign_err=%b expected 0 0 at cyc %0d",
                              wb_we, misalign_err, cyc);
            end
        end
    end

    function automatic exp_t mk(input logic [5:0] r, input logic [63:0] v,
                                input logic we, input logic mis, input int c);
        exp_t e;
        e.r = r; e.v = v; e.we = we; e.mis = mis; e.cyc = c;
        return e;
    endfunction

    task automatic drive_op(input logic act, input logic ld, input logic [1:0] sz, input logic uns,
                            input logic [63:0] a, input logic [63:0] sd, input logic [5:0] d);
        EXMEM_ready = 1'b1; mem_active = act; load = ld; mem_size = sz;
        mem_unsigned = uns; exmm_aluresult = a; store_data = sd; dest_reg = d;
    endtask

    task automatic alu_op(input logic [63:0] val, input logic [5:0] d);
        q.push_back(mk(d, val, d != 6'd0, 1'b0, cyc + 1));
        drive_op(1'b0, 1'b0, 2'd0, 1'b0, val, 64'd0, d);
        @(posedge clk); #1 EXMEM_ready = 1'b0;
        @(negedge clk);
        chk("alu_no_req", mem_req, 0);
    endtask

    task automatic misaligned_op(input logic ld, input logic [1:0] sz, input logic [63:0] a,
                                 input logic [5:0] d);
        q.push_back(mk(d, a, 1'b0, 1'b1, cyc + 1));
        drive_op(1'b1, ld, sz, 1'b0, a, 64'h1111, d);
        @(posedge clk); #1 EXMEM_ready = 1'b0;
        @(negedge clk);
        chk("mis_no_req", mem_req, 0);
        chk("mis_no_stall", mem_stall, 0);
    endtask

    // Aligned access; hold=1 keeps an add (0x55 -> x7) on EXMEM_ready through the stall
    task automatic mem_op(input logic ld, input logic [1:0] sz, input logic uns,
                          input logic [63:0] a, input logic [63:0] sd, input logic [5:0] d,
                          input int gd, input int rd, input logic [63:0] rdata,
                          input logic [63:0] exp_v, input logic hold);
        int c;
        c = cyc;
        q.push_back(mk(d, exp_v, ld && (d != 6'd0), 1'b0, c + 3 + gd + rd));
        if (hold) q.push_back(mk(6'd7, 64'h55, 1'b1, 1'b0, c + 4 + gd + rd));
        drive_op(1'b1, ld, sz, uns, a, sd, d);
        @(posedge clk); #1;
        if (hold) begin
            mem_active = 1'b0; exmm_aluresult = 64'h55; dest_reg = 6'd7;
        end else begin
            EXMEM_ready = 1'b0;
        end
        @(negedge clk);
        chk("req_high", mem_req, 1);
        chk("stall_req", mem_stall, 1);
        chk("req_addr", mem_addr, a);
        chk("req_size", mem_wsize, sz);
        chk("req_we", mem_we, !ld);
        if (!ld) chk("req_wdata", mem_wdata, sd);
        repeat (gd) begin
            @(posedge clk); @(negedge clk);
            chk("req_held", mem_req, 1);
            chk("addr_held", mem_addr, a);
            chk("size_held", mem_wsize, sz);
        end
        mem_gnt = 1'b1;
        @(posedge clk); #1 mem_gnt = 1'b0;
        @(negedge clk);
        chk("wait_req_low", mem_req, 0);
        chk("stall_wait", mem_stall, 1);
        repeat (rd) begin
            @(posedge clk); @(negedge clk);
        end
        mem_rvalid = 1'b1; mem_rdata = rdata;
        @(posedge clk); #1 mem_rvalid = 1'b0; mem_rdata = 64'd0;
        @(negedge clk);
        chk("stall_drop", mem_stall, 0);
        if (hold) begin
            @(posedge clk); #1 EXMEM_ready = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1; EXMEM_ready = 1'b0; exmm_aluresult = 64'd0; dest_reg = 6'd0;
        mem_active = 1'b0; load = 1'b0; mem_size = 2'd0; mem_unsigned = 1'b0;
        store_data = 64'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_req", mem_req, 0);
        chk("rst_stall", mem_stall, 0);
        chk("rst_memwb", MEMWB_ready, 0);
        chk("rst_wb_value", wb_value, 0);
        chk("rst_wb_reg", wb_reg, 0);

        alu_op(64'h1234, 6'd5);
        alu_op(64'hABCD, 6'd0);

        // Back-to-back non-mem and misaligned ops, one per cycle
        q.push_back(mk(6'd1, 64'h11, 1'b1, 1'b0, cyc + 1));
        q.push_back(mk(6'd2, 64'h202, 1'b0, 1'b1, cyc + 2));
        q.push_back(mk(6'd3, 64'h33, 1'b1, 1'b0, cyc + 3));
        drive_op(1'b0, 1'b0, 2'd0, 1'b0, 64'h11, 64'd0, 6'd1);
        @(posedge clk); #1 drive_op(1'b1, 1'b1, 2'd2, 1'b0, 64'h202, 64'd0, 6'd2);
        @(posedge clk); #1 drive_op(1'b0, 1'b0, 2'd0, 1'b0, 64'h33, 64'd0, 6'd3);
        @(posedge clk); #1 EXMEM_ready = 1'b0;
        @(negedge clk);

        mem_op(1'b1, 2'd0, 1'b0, 64'h100, 64'd0, 6'd10, 0, 0, 64'h80, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
        mem_op(1'b1, 2'd0, 1'b1, 64'h100, 64'd0, 6'd10, 0, 0, 64'h80, 64'h80, 1'b0);
        mem_op(1'b1, 2'd2, 1'b0, 64'h200, 64'd0, 6'd11, 3, 1, 64'h0000_0000_8765_4321,
               64'hFFFF_FFFF_8765_4321, 1'b1);
        mem_op(1'b0, 2'd3, 1'b0, 64'h208, 64'hDEAD_BEEF_CAFE_F00D, 6'd12, 0, 2, 64'd0, 64'd0, 1'b0);
        mem_op(1'b1, 2'd1, 1'b1, 64'h302, 64'd0, 6'd13, 1, 0, 64'h1234_5678_9ABC_F00D, 64'hF00D, 1'b0);
        mem_op(1'b1, 2'd1, 1'b0, 64'h302, 64'd0, 6'd13, 0, 0, 64'h1234_5678_9ABC_F00D,
               64'hFFFF_FFFF_FFFF_F00D, 1'b0);
        mem_op(1'b1, 2'd3, 1'b1, 64'h310, 64'd0, 6'd14, 0, 0, 64'h8000_0000_0000_0001,
               64'h8000_0000_0000_0001, 1'b0);
        mem_op(1'b1, 2'd0, 1'b0, 64'h101, 64'd0, 6'd0, 0, 0, 64'h7F, 64'h7F, 1'b0);

        misaligned_op(1'b1, 2'd1, 64'h1001, 6'd9);
        misaligned_op(1'b0, 2'd3, 64'h20C, 6'd4);

        // Reset while waiting for the response; the late response must be dropped
        drive_op(1'b1, 1'b1, 2'd2, 1'b0, 64'h400, 64'd0, 6'd3);
        @(posedge clk); #1 EXMEM_ready = 1'b0;
        @(negedge clk);
        mem_gnt = 1'b1;
        @(posedge clk); #1 mem_gnt = 1'b0;
        @(negedge clk);
        chk("pre_rst_wait", mem_stall, 1);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_stall", mem_stall, 0);
        chk("abort_req", mem_req, 0);
        chk("abort_memwb", MEMWB_ready, 0);
        chk("abort_wb_value", wb_value, 0);
        chk("abort_addr", mem_addr, 0);
        mem_rvalid = 1'b1; mem_rdata = 64'hFFFF;
        @(posedge clk); #1 mem_rvalid = 1'b0;
        @(negedge clk);
        chk("late_rvalid_memwb", MEMWB_ready, 0);
        chk("late_rvalid_stall", mem_stall, 0);

        alu_op(64'h1234, 6'd5);

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage of the RISC-V core, directly downstream of the execute stage. It takes the EX/MEM bundle: ALU result or effective address, destination register, memory-active/load flags, size and store data. Non-memory ops pass to writeback after one register stage. Loads and stores run a request/grant/response handshake with data memory, and the upstream stage is stalled until the access completes. It produces the MEM/WB bundle with load sign/zero extension and misalignment detection.

## Interface
- ADDR_W, 64, address width; data path fixed at 64 bits
- REG_W, 6, destination-register field width (matches `dest_reg`)
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- EXMEM_ready  in  1  EX/MEM bundle valid this cycle
- exmm_aluresult  in  64  ALU result (non-mem op) or effective address (mem op)
- dest_reg  in  REG_W  destination register
- mem_active  in  1  op accesses memory
- load  in  1  1 = load, 0 = store (meaningful only when `mem_active`=1)
- mem_size  in  2  0=B, 1=H, 2=W, 3=D
- mem_unsigned  in  1  zero-extend load (LBU/LHU/LWU)
- store_data  in  64  store value, right-justified
- mem_stall  out  1  upstream must hold its EX/MEM outputs
- mem_req  out  1  memory request valid
- mem_we  out  1  request is a write
- mem_addr  out  ADDR_W  request address
- mem_wsize  out  2  request size, same encoding as `mem_size`
- mem_wdata  out  64  write data, right-justified
- mem_gnt  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  response valid (read data, or write ack)
- mem_rdata  in  64  read data, right-justified by memory
- MEMWB_ready  out  1  MEM/WB bundle valid (one-cycle pulse per op)
- wb_reg  out  REG_W  writeback register
- wb_value  out  64  writeback value
- wb_we  out  1  writeback enable
- misalign_err  out  1  accompanies `MEMWB_ready` for a misaligned access

## Operation
- FSM states:
  - IDLE: accepting ops.
  - REQ: `mem_req` held high.
  - WAIT: awaiting `mem_rvalid`.
- Accept condition: `EXMEM_ready` && state==IDLE. `EXMEM_ready` is ignored in REQ and WAIT.
- Non-mem op accepted (`mem_active`=0):
  - next cycle `MEMWB_ready`=1, `wb_value`=`exmm_aluresult`, `wb_reg`=`dest_reg`.
  - `wb_we` = (`dest_reg`!=0).
  - state stays IDLE.
- Mem op accepted, aligned: latch address, size, unsigned flag, store data, dest and load/store; go to REQ.
- Alignment rule: address low bits must be zero for the size. H needs addr[0]=0, W needs addr[1:0]=0, D needs addr[2:0]=0, B is always aligned.
- Misaligned mem op:
  - no memory request is issued; state stays IDLE.
  - next cycle `MEMWB_ready`=1, `misalign_err`=1, `wb_we`=0, `wb_value`=address.
- REQ: `mem_req`=1, with `mem_we`=!load and `mem_addr`/`mem_wsize`/`mem_wdata` from the latches. These are stable until grant. On `mem_req`&&`mem_gnt` go to WAIT.
- WAIT: on `mem_rvalid`, capture the result and go to IDLE. `mem_rvalid` outside WAIT is ignored.
- Load result extension:
  - B takes rdata[7:0], H takes [15:0], W takes [31:0], D takes [63:0].
  - Sign-extend unless `mem_unsigned`. `mem_unsigned` with D is treated as D.
  - `wb_we` = (dest!=0).
- Store completion: `MEMWB_ready`=1, `wb_we`=0, `wb_value`=0.
- `mem_stall` = (state!=IDLE), combinational from state.
- Register 0 is never written: `wb_we`=0 whenever `wb_reg`=0.

## Timing
- Reset (synchronous): state=IDLE; all outputs 0, including `mem_req`, `MEMWB_ready`, `wb_*`, `misalign_err` and `mem_stall`.
- Reset during REQ or WAIT aborts the op with no MEM/WB output. A late `mem_rvalid` after reset is ignored.
- Non-mem and misaligned ops: 1-cycle latency, throughput 1 per cycle, back-to-back without bubble.
- Mem op timing:
  - accept at edge 0, so `mem_req` and `mem_stall` are high from cycle 1.
  - grant at edge g, so state is WAIT from cycle g+1.
  - `mem_rvalid` sampled at edge r (r>g), so `MEMWB_ready` is high in cycle r+1.
  - minimum total is 3 cycles from accept to `MEMWB_ready` (1 REQ cycle, 1 WAIT cycle).
- `mem_stall` falls in cycle r+1. The held upstream op can be accepted at edge r+1.
- `MEMWB_ready` is a single-cycle pulse. Between ops it returns to 0; `wb_*` hold their last values, but `wb_we`=0 when `MEMWB_ready`=0.

## Test plan
- Reset, then `add` result 0x1234 to dest 5 with `EXMEM_ready` pulse: next cycle `MEMWB_ready`=1, `wb_reg`=5, `wb_value`=0x1234, `wb_we`=1; `mem_req` stays 0.
- LB at 0x100, `mem_gnt` immediate, `mem_rdata`=0x80 one cycle later: `wb_value`=0xFFFF_FFFF_FFFF_FF80. Repeat as LBU: `wb_value`=0x80. Latency is 3 cycles, with `mem_stall` high for 2.
- LW at 0x200 with `mem_gnt` delayed 3 cycles: `mem_req`, `mem_addr`=0x200 and `mem_wsize`=2 stay stable until grant. An `EXMEM_ready` asserted during the stall is not accepted until after `MEMWB_ready`.
- SD to 0x208 with `store_data` 0xDEAD_BEEF_CAFE_F00D: `mem_we`=1 and `mem_wdata` matches. On ack, `MEMWB_ready`=1 with `wb_we`=0.
- LH at 0x1001: no `mem_req`; next cycle `misalign_err`=1, `MEMWB_ready`=1, `wb_we`=0, `wb_value`=0x1001.
- Reset asserted in WAIT, then `mem_rvalid` pulses: state is IDLE, no `MEMWB_ready`, all outputs 0. A following `add` completes normally.
